time_sync_slave_mb: RTL and testbench

Multi-beat, parametrised time synchronization slave. It receives a sync packet over AXI-Stream and reassembles the 18-byte sync header across beats of any supported width. It filters the packet by magic, destination ID, frame error and ToD validity, then adds a programmable link-delay compensation to the timestamp. On success it issues a one-cycle write to the PTP clock. It sits between the sync RX queue and the PTP clock write port; it also exports the last accepted source ID and per-outcome counters.

---
 rtl/time_sync_slave_mb.sv | 164 ++++++++++++++++
 tb/tb_time_sync_slave_mb.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_sync_slave_mb.sv
// rtl/time_sync_slave_mb.sv - multi-beat sync packet receiver driving PTP clock writes
// Reassembles the 18-byte sync header, filters it and applies link-delay compensation.
module time_sync_slave_mb #(
  parameter int          AXIS_DATA_WIDTH    = 64,
  parameter int          AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH/8,
  parameter int          AXIS_RX_ID_WIDTH   = 8,
  parameter int          AXIS_RX_DEST_WIDTH = 8,
  parameter int          AXIS_RX_USER_WIDTH = 1,
  parameter int          IDENTIFIER_WIDTH   = 16,
  parameter logic [15:0] SELF_ID            = 16'h0001,
  parameter logic [15:0] BROADCAST_ID       = 16'hFFFF,
  parameter logic [15:0] SYNC_MAGIC         = 16'h77F8,
  parameter int          CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [31:0]                   link_delay_ns,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_sync_rx_data,
  input  logic [AXIS_KEEP_WIDTH-1:0]    s_axis_sync_rx_keep,
  input  logic                          s_axis_sync_rx_valid,
  output logic                          s_axis_sync_rx_ready,
  input  logic                          s_axis_sync_rx_last,
  input  logic [AXIS_RX_ID_WIDTH-1:0]   s_axis_sync_rx_id,
  input  logic [AXIS_RX_DEST_WIDTH-1:0] s_axis_sync_rx_dest,
  input  logic [AXIS_RX_USER_WIDTH-1:0] s_axis_sync_rx_user,
  output logic                          time_sync_wr_en,
  output logic [95:0]                   time_sync_wr_ts,
  output logic [IDENTIFIER_WIDTH-1:0]   last_src_id,
  output logic [CNT_WIDTH-1:0]          sync_accept_cnt,
  output logic [CNT_WIDTH-1:0]          sync_drop_cnt
);

  localparam int HB = (144 + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
  localparam int HW = HB * AXIS_DATA_WIDTH;
  localparam int IW = $clog2(HB + 1);
  localparam logic [32:0] NS_PER_SEC = 33'd1_000_000_000;

  typedef enum logic [1:0] {HDR, TAIL, CHECK, WRITE} state_t;

  state_t                state, state_next;
  logic [HW-1:0]         hdr;
  logic [IW-1:0]         beat_idx;
  logic                  bad;
  logic                  runt;
  logic                  fire;
  logic                  run;
  logic [15:0]           keep_cnt;
  logic [15:0]           last_bytes;
  logic [32:0]           ns_sum;
  logic [31:0]           ns_comp;
  logic [47:0]           sec_comp;
  logic                  accept;
  logic [15:0]           hdr_magic, hdr_dst;
  logic [IDENTIFIER_WIDTH-1:0] hdr_src;
  logic [47:0]           hdr_sec;
  logic [31:0]           hdr_ns;
  logic [15:0]           hdr_fns;
  logic                  unused_ok;

  assign s_axis_sync_rx_ready = (state == HDR) || (state == TAIL);
  assign fire = s_axis_sync_rx_valid && s_axis_sync_rx_ready;

  assign hdr_magic = hdr[15:0];
  assign hdr_dst   = hdr[31:16];
  assign hdr_src   = hdr[32 +: IDENTIFIER_WIDTH];
  assign hdr_fns   = hdr[63:48];
  assign hdr_ns    = hdr[95:64];
  assign hdr_sec   = hdr[143:96];

  assign unused_ok = ^{s_axis_sync_rx_id, s_axis_sync_rx_dest, s_axis_sync_rx_user, hdr[HW-1:144]};

  // Valid bytes on a tlast beat: full header beats so far plus the contiguous low keep run.
  always_comb begin
    keep_cnt = '0;
    run      = 1'b1;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      if (run && s_axis_sync_rx_keep[i]) keep_cnt = keep_cnt + 16'd1;
      else run = 1'b0;
    end
  end
  assign last_bytes = 16'(beat_idx) * 16'(AXIS_KEEP_WIDTH) + keep_cnt;

  always_comb begin
    ns_sum = {1'b0, hdr_ns} + {1'b0, link_delay_ns};
    if (ns_sum >= NS_PER_SEC) begin
      ns_comp  = 32'(ns_sum - NS_PER_SEC);
      sec_comp = hdr_sec + 48'd1;
    end else begin
      ns_comp  = ns_sum[31:0];
      sec_comp = hdr_sec;
    end
  end

  assign accept = !runt && !bad && enable
                && (hdr_magic == SYNC_MAGIC)
                && ((hdr_dst == SELF_ID) || (hdr_dst == BROADCAST_ID))
                && (hdr_ns < NS_PER_SEC[31:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HDR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (fire) begin
          if (s_axis_sync_rx_last)           state_next = CHECK;
          else if (beat_idx == IW'(HB - 1))  state_next = TAIL;
        end
      end
      TAIL:    if (fire && s_axis_sync_rx_last) state_next = CHECK;
      CHECK:   state_next = WRITE;
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr             <= '0;
      beat_idx        <= '0;
      bad             <= 1'b0;
      runt            <= 1'b0;
      time_sync_wr_en <= 1'b0;
      time_sync_wr_ts <= '0;
      last_src_id     <= '0;
      sync_accept_cnt <= '0;
      sync_drop_cnt   <= '0;
    end else begin
      time_sync_wr_en <= 1'b0;
      case (state)
        HDR: begin
          if (fire) begin
            for (int b = 0; b < HB; b++)
              if (beat_idx == IW'(b)) hdr[b*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] <= s_axis_sync_rx_data;
            bad      <= bad | s_axis_sync_rx_user[0];
            beat_idx <= beat_idx + 1'b1;
            if (s_axis_sync_rx_last) runt <= (last_bytes < 16'd18);
          end
        end
        TAIL: if (fire) bad <= bad | s_axis_sync_rx_user[0];
        // Results are registered here so they are visible during the WRITE cycle.
        CHECK: begin
          time_sync_wr_en <= accept;
          if (accept) begin
            time_sync_wr_ts <= {sec_comp, ns_comp, hdr_fns};
            last_src_id     <= hdr_src;
            sync_accept_cnt <= sync_accept_cnt + 1'b1;
          end else begin
            sync_drop_cnt   <= sync_drop_cnt + 1'b1;
          end
        end
        default: begin
          beat_idx <= '0;
          bad      <= 1'b0;
          runt     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_sync_slave_mb.sv
// tb/tb_time_sync_slave_mb.sv - scoreboard bench for time_sync_slave_mb at widths 32/64/256
module tb_time_sync_slave_mb;

  typedef byte unsigned bq_t[$];
  typedef struct packed {
    logic [1:0]  k;
    logic        acc;
    logic [95:0] ts;
    logic [15:0] src;
    logic [63:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        enable;
  logic [31:0] delay;
  logic [31:0]  d32;  logic [3:0]  k32;
  logic [63:0]  d64;  logic [7:0]  k64;
  logic [255:0] d256; logic [31:0] k256;
  logic [2:0]  vld, lst, usr;
  wire  [2:0]  rdy, wen;
  wire  [95:0] ts  [3];
  wire  [15:0] src [3];
  wire  [15:0] acc [3];
  wire  [15:0] drp [3];

  int        n_chk = 0;
  int        n_fail = 0;
  longint    cyc = 0;
  exp_t      q[$];
  exp_t      me;
  bit        pend = 1'b0;
  int        n_acc [3];
  int        n_drop [3];
  logic [95:0] m_ts [3];
  logic [15:0] m_src [3];
  logic [15:0] prev_drp [3];

  time_sync_slave_mb #(.AXIS_DATA_WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .enable(enable), .link_delay_ns(delay),
    .s_axis_sync_rx_data(d32), .s_axis_sync_rx_keep(k32), .s_axis_sync_rx_valid(vld[0]),
    .s_axis_sync_rx_ready(rdy[0]), .s_axis_sync_rx_last(lst[0]), .s_axis_sync_rx_id(8'h00),
    .s_axis_sync_rx_dest(8'h00), .s_axis_sync_rx_user(usr[0]), .time_sync_wr_en(wen[0]),
    .time_sync_wr_ts(ts[0]), .last_src_id(src[0]), .sync_accept_cnt(acc[0]), .sync_drop_cnt(drp[0]));

  time_sync_slave_mb #(.AXIS_DATA_WIDTH(64)) u_w64 (
    .clk(clk), .rst(rst), .enable(enable), .link_delay_ns(delay),
    .s_axis_sync_rx_data(d64), .s_axis_sync_rx_keep(k64), .s_axis_sync_rx_valid(vld[1]),
    .s_axis_sync_rx_ready(rdy[1]), .s_axis_sync_rx_last(lst[1]), .s_axis_sync_rx_id(8'h00),
    .s_axis_sync_rx_dest(8'h00), .s_axis_sync_rx_user(usr[1]), .time_sync_wr_en(wen[1]),
    .time_sync_wr_ts(ts[1]), .last_src_id(src[1]), .sync_accept_cnt(acc[1]), .sync_drop_cnt(drp[1]));

  time_sync_slave_mb #(.AXIS_DATA_WIDTH(256)) u_w256 (
    .clk(clk), .rst(rst), .enable(enable), .link_delay_ns(delay),
    .s_axis_sync_rx_data(d256), .s_axis_sync_rx_keep(k256), .s_axis_sync_rx_valid(vld[2]),
    .s_axis_sync_rx_ready(rdy[2]), .s_axis_sync_rx_last(lst[2]), .s_axis_sync_rx_id(8'h00),
    .s_axis_sync_rx_dest(8'h00), .s_axis_sync_rx_user(usr[2]), .time_sync_wr_en(wen[2]),
    .time_sync_wr_ts(ts[2]), .last_src_id(src[2]), .sync_accept_cnt(acc[2]), .sync_drop_cnt(drp[2]));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int kw_of(int k);
    return (k == 0) ? 4 : ((k == 1) ? 8 : 32);
  endfunction

  function automatic bq_t build(logic [15:0] magic, logic [15:0] dst, logic [15:0] s,
                                logic [47:0] sec, logic [31:0] ns, logic [15:0] fns, int len);
    bq_t b;
    logic [143:0] h;
    h = {sec, ns, fns, s, dst, magic};
    for (int i = 0; i < len; i++) begin
      if (i < 18) b.push_back(h[i*8 +: 8]);
      else        b.push_back(8'($urandom));
    end
    return b;
  endfunction

  // Reference: decide the outcome from the byte list and compute the ToD with plain arithmetic.
  function automatic exp_t model(int k, bq_t b, bit bad, logic en, logic [31:0] dly);
    exp_t e;
    logic [15:0] magic, dst, fns;
    logic [31:0] ns;
    logic [47:0] sec;
    longint t;
    e = '0;
    e.k = 2'(k);
    if (b.size() < 18) return e;
    magic = {b[1], b[0]};
    dst   = {b[3], b[2]};
    e.src = {b[5], b[4]};
    fns   = {b[7], b[6]};
    ns    = {b[11], b[10], b[9], b[8]};
    sec   = {b[17], b[16], b[15], b[14], b[13], b[12]};
    if (magic != 16'h77F8 || !(dst == 16'h0001 || dst == 16'hFFFF) || bad || !en
        || ns >= 32'd1_000_000_000) return e;
    t = longint'(ns) + longint'(dly);
    e.ts  = {sec + 48'(t / 1000000000), 32'(t % 1000000000), fns};
    e.acc = 1'b1;
    return e;
  endfunction

  task automatic drive(int k, logic [255:0] d, logic [31:0] kp, logic v, logic l, logic u);
    vld[k] = v; lst[k] = l; usr[k] = u;
    if (k == 0)      begin d32 = d[31:0]; k32 = kp[3:0]; end
    else if (k == 1) begin d64 = d[63:0]; k64 = kp[7:0]; end
    else             begin d256 = d;      k256 = kp;     end
  endtask

  task automatic quiesce();
    @(negedge clk);
    vld = '0; lst = '0; usr = '0;
    pend = 1'b0;
  endtask

  task automatic send_packet(int k, bq_t b, int ub, logic en, logic [31:0] dly, int abort_at);
    int kw, nb, rem, waits, idx;
    bit gap;
    logic [255:0] d;
    logic [31:0] kp;
    exp_t e;
    kw = kw_of(k);
    nb = (b.size() + kw - 1) / kw;
    if (en !== enable || dly !== delay) begin
      quiesce();
      waits = 0;
      while (!rdy[k] && waits < 100) begin @(negedge clk); waits++; end
      enable = en;
      delay  = dly;
    end
    for (int bi = 0; bi < nb; bi++) begin
      if (bi == abort_at) return;
      @(negedge clk);
      gap = ($urandom_range(0, 3) == 0);
      if (gap) begin
        vld[k] = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      for (int j = 0; j < 32; j++) begin
        idx = bi*kw + j;
        if (j < kw && idx < b.size()) d[j*8 +: 8] = b[idx];
        else                          d[j*8 +: 8] = 8'($urandom);
      end
      rem = b.size() - bi*kw;
      if (bi == nb - 1) kp = (rem >= 32) ? 32'hFFFF_FFFF : ((32'd1 << rem) - 32'd1);
      else              kp = $urandom;
      drive(k, d, kp, 1'b1, bi == nb - 1, bi == ub);
      waits = 0;
      while (!rdy[k]) begin
        if (waits == 100) begin
          $display("FAIL ready_timeout: ready stuck low on dut %0d", k);
          n_fail++;
          $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
          $fatal(1, "ready timeout");
        end
        @(negedge clk);
        waits++;
      end
      if (bi == 0 && pend && !gap) chk("ready_gap", waits, 2);
      if (bi == 0) pend = 1'b0;
      if (bi == nb - 1) begin
        e = model(k, b, ub >= 0, en, dly);
        e.cyc = 64'(cyc + 2);
        q.push_back(e);
        pend = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int t;
    quiesce();
    t = 0;
    while (q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk("drain", q.size(), 0);
  endtask

  task automatic check_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", rdy[k], 1'b1);
      chk("rst_wr_en", wen[k], 1'b0);
      chk("rst_wr_ts", ts[k], 96'd0);
      chk("rst_src", src[k], 16'd0);
      chk("rst_acc", acc[k], 16'd0);
      chk("rst_drop", drp[k], 16'd0);
    end
  endtask

  task automatic reset_mid(int k);
    drain();
    send_packet(k, build(16'h77F8, 16'h0001, 16'h0BAD, 48'd9, 32'd9, 16'd9, 40), -1,
                enable, delay, (k == 2) ? 1 : 2);
    quiesce();
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset();
    #2 rst = 1'b0;
  endtask

  // Monitor: every wr_en pulse or drop-count step consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        n_acc[k] = 0; n_drop[k] = 0; m_ts[k] = '0; m_src[k] = '0; prev_drp[k] = '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wen[k] || drp[k] != prev_drp[k]) begin
          prev_drp[k] = drp[k];
          if (q.size() == 0 || int'(q[0].k) != k) begin
            chk("unexpected_event", k, 3);
          end else begin
            me = q.pop_front();
            chk("outcome", wen[k], me.acc);
            chk("latency", 64'(cyc), me.cyc);
            if (me.acc) begin n_acc[k]++; m_ts[k] = me.ts; m_src[k] = me.src; end
            else n_drop[k]++;
            chk("wr_ts", ts[k], m_ts[k]);
            chk("last_src_id", src[k], m_src[k]);
            chk("accept_cnt", acc[k], 16'(n_acc[k]));
            chk("drop_cnt", drp[k], 16'(n_drop[k]));
          end
        end
      end
      if (q.size() > 0 && 64'(cyc) > q[0].cyc) begin
        chk("missing_event", 64'(cyc), q[0].cyc);
        me = q.pop_front();
      end
    end
  end

  initial begin
    bq_t p;
    logic [15:0] mg, ds;
    logic [31:0] ns, dly;
    logic [47:0] sec;
    int len, ub, nb;
    logic en;

    enable = 1'b1; delay = 32'd0;
    vld = '0; lst = '0; usr = '0;
    d32 = '0; k32 = '0; d64 = '0; k64 = '0; d256 = '0; k256 = '0;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;

    send_packet(1, build(16'h77F8, 16'h0001, 16'h0ABC, 48'd5, 32'd100, 16'd7, 18), -1, 1'b1, 32'd20, -1);
    drain();
    chk("basic_ts", ts[1], {48'd5, 32'd120, 16'd7});
    chk("basic_src", src[1], 16'h0ABC);
    send_packet(1, build(16'h77F8, 16'h0001, 16'h0ABC, 48'd5, 32'd999_999_990, 16'd7, 18), -1, 1'b1, 32'd20, -1);
    drain();
    chk("carry_ts", ts[1], {48'd6, 32'd10, 16'd7});
    send_packet(1, build(16'h77F8, 16'h0001, 16'h0ABC, 48'hFFFF_FFFF_FFFF, 32'd999_999_990, 16'd7, 18), -1, 1'b1, 32'd20, -1);
    drain();
    chk("sec_wrap_ts", ts[1], {48'd0, 32'd10, 16'd7});

    send_packet(1, build(16'h77F8, 16'hFFFF, 16'h0C01, 48'd1, 32'd1, 16'd1, 18), -1, 1'b1, 32'd20, -1);
    send_packet(1, build(16'h77F8, 16'h0002, 16'h0C02, 48'd1, 32'd1, 16'd1, 18), -1, 1'b1, 32'd20, -1);
    send_packet(1, build(16'h77F9, 16'h0001, 16'h0C03, 48'd1, 32'd1, 16'd1, 18), -1, 1'b1, 32'd20, -1);
    send_packet(1, build(16'h77F8, 16'h0001, 16'h0C04, 48'd1, 32'd1, 16'd1, 17), -1, 1'b1, 32'd20, -1);
    send_packet(1, build(16'h77F8, 16'h0001, 16'h0C05, 48'd1, 32'd1, 16'd1, 18), -1, 1'b1, 32'd20, -1);
    send_packet(1, build(16'h77F8, 16'h0001, 16'h0C06, 48'd1, 32'd1, 16'd1, 40),  4, 1'b1, 32'd20, -1);
    send_packet(1, build(16'h77F8, 16'h0001, 16'h0C07, 48'd1, 32'd1, 16'd1, 18), -1, 1'b0, 32'd20, -1);
    send_packet(1, build(16'h77F8, 16'h0001, 16'h0C08, 48'd1, 32'd1_000_000_000, 16'd1, 18), -1, 1'b1, 32'd20, -1);
    drain();
    chk("directed_acc", acc[1], 16'd5);
    chk("directed_drop", drp[1], 16'd6);
    chk("directed_src", src[1], 16'h0C05);

    for (int k = 0; k < 3; k++) begin
      reset_mid(k);
      send_packet(k, build(16'h77F8, 16'h0001, 16'h0ABC, 48'd5, 32'd100, 16'd7, 18), -1, 1'b1, 32'd20, -1);
      drain();
      chk("post_rst_ts", ts[k], {48'd5, 32'd120, 16'd7});
      chk("post_rst_acc", acc[k], 16'd1);
      chk("post_rst_drop", drp[k], 16'd0);
    end

    for (int k = 0; k < 3; k++) begin
      dly = 32'd20;
      for (int i = 0; i < 30; i++) begin
        mg = ($urandom_range(0, 7) == 0) ? 16'h77F9 : 16'h77F8;
        case ($urandom_range(0, 5))
          0:       ds = 16'hFFFF;
          1:       ds = 16'h0002;
          2:       ds = 16'($urandom);
          default: ds = 16'h0001;
        endcase
        case ($urandom_range(0, 4))
          0:       ns = 32'd1_000_000_000 - $urandom_range(1, 50);
          1:       ns = 32'd1_000_000_000 + $urandom_range(0, 5);
          2:       ns = $urandom_range(0, 50);
          default: ns = $urandom % 32'd1_000_000_000;
        endcase
        sec = ($urandom_range(0, 5) == 0) ? 48'hFFFF_FFFF_FFFF : 48'({$urandom, $urandom});
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 17) : $urandom_range(18, 50);
        nb  = (len + kw_of(k) - 1) / kw_of(k);
        ub  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nb - 1) : -1;
        en  = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 5) == 0) dly = $urandom % 32'd1_000_000_000;
        send_packet(k, build(mg, ds, 16'($urandom), sec, ns, 16'($urandom), len), ub, en, dly, -1);
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
